// File: rtl/uart_token_parser_pkg.sv
// Shared ASCII constants, error codes and parser state encoding for the UART
// text input path.
package uart_token_parser_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL    = 3'd1;
    localparam logic [2:0] ERR_DIGITS     = 3'd2;
    localparam logic [2:0] ERR_LONE_MINUS = 3'd3;
    localparam logic [2:0] ERR_OVERRUN    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SIGN,
        ST_DIGITS,
        ST_SKIP
    } parser_state_t;

endpackage

// File: rtl/ascii_classifier.sv
// Combinational byte classifier shared by the token and command parsers.
module ascii_classifier
    import uart_token_parser_pkg::*;
(
    input  logic [7:0] rx_byte,
    output logic       is_digit,
    output logic       is_delim,
    output logic       is_eol,
    output logic       is_minus,
    output logic [3:0] digit_val
);

    // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
    always_comb begin
        is_digit  = (rx_byte >= ASCII_ZERO) && (rx_byte <= ASCII_NINE);
        is_eol    = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
        is_delim  = (rx_byte == ASCII_SPACE) || (rx_byte == ASCII_TAB) || is_eol;
        is_minus  = (rx_byte == ASCII_MINUS);
        digit_val = is_digit ? rx_byte[3:0] : 4'd0;
    end

endmodule

// File: rtl/uart_token_parser.sv
// Turns the UART byte stream into signed decimal tokens with an end-of-line
// flag, a valid/ready output holding register and error reporting.
module uart_token_parser
    import uart_token_parser_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [DATA_W-1:0] o_tok_value,
    output logic              o_tok_last,
    output logic              o_tok_valid,
    input  logic              i_tok_ready,
    output logic              o_err,
    output logic [2:0]        o_err_code,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    parser_state_t     state, state_n;
    logic [DATA_W-1:0] acc, acc_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              neg, neg_n;

    logic              is_digit, is_delim, is_eol, is_minus;
    logic [3:0]        digit_val;
    logic [DATA_W-1:0] digit_ext;
    logic [DATA_W-1:0] tok_new;

    logic              emit, overrun;
    logic              err_hit;
    logic [2:0]        err_hit_code;

    ascii_classifier u_classifier (
        .rx_byte   (i_rx_data),
        .is_digit  (is_digit),
        .is_delim  (is_delim),
        .is_eol    (is_eol),
        .is_minus  (is_minus),
        .digit_val (digit_val)
    );

    assign digit_ext = {{(DATA_W-4){1'b0}}, digit_val};
    assign tok_new   = neg ? -acc : acc;
    assign o_busy    = (state == ST_SIGN) || (state == ST_DIGITS);

    // Next-state, accumulator update and error/emit decisions for one byte.
    always_comb begin
        state_n      = state;
        acc_n        = acc;
        cnt_n        = cnt;
        neg_n        = neg;
        emit         = 1'b0;
        err_hit      = 1'b0;
        err_hit_code = ERR_NONE;

        if (i_rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_digit) begin
                        state_n = ST_DIGITS;
                        acc_n   = digit_ext;
                        cnt_n   = CNT_W'(1);
                    end else if (is_minus) begin
                        state_n = ST_SIGN;
                        neg_n   = 1'b1;
                    end else if (!is_delim) begin
                        state_n      = ST_SKIP;
                        err_hit      = 1'b1;
                        err_hit_code = ERR_ILLEGAL;
                    end
                end
                ST_SIGN: begin
                    if (is_digit) begin
                        state_n = ST_DIGITS;
                        acc_n   = digit_ext;
                        cnt_n   = CNT_W'(1);
                    end else if (is_delim) begin
                        state_n      = ST_IDLE;
                        neg_n        = 1'b0;
                        err_hit      = 1'b1;
                        err_hit_code = ERR_LONE_MINUS;
                    end else begin
                        state_n      = ST_SKIP;
                        neg_n        = 1'b0;
                        err_hit      = 1'b1;
                        err_hit_code = ERR_ILLEGAL;
                    end
                end
                ST_DIGITS: begin
                    if (is_digit && (cnt < CNT_MAX)) begin
                        acc_n = (acc << 3) + (acc << 1) + digit_ext;
                        cnt_n = cnt + 1'b1;
                    end else begin
                        acc_n = '0;
                        cnt_n = '0;
                        neg_n = 1'b0;
                        if (is_delim) begin
                            state_n = ST_IDLE;
                            emit    = 1'b1;
                        end else begin
                            state_n      = ST_SKIP;
                            err_hit      = 1'b1;
                            err_hit_code = is_digit ? ERR_DIGITS : ERR_ILLEGAL;
                        end
                    end
                end
                ST_SKIP: begin
                    if (is_delim) begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        // A completed token only collides with a held token the consumer is refusing.
        overrun = emit && o_tok_valid && !i_tok_ready;
        if (overrun) begin
            err_hit      = 1'b1;
            err_hit_code = ERR_OVERRUN;
        end
    end

    // Parser state plus the output holding register; clear acts like reset.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            o_tok_value <= '0;
            o_tok_last  <= 1'b0;
            o_tok_valid <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= ERR_NONE;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            neg   <= neg_n;
            o_err <= err_hit;
            if (err_hit) begin
                o_err_code <= err_hit_code;
            end
            if (emit && !overrun) begin
                o_tok_value <= tok_new;
                o_tok_last  <= is_eol;
                o_tok_valid <= 1'b1;
            end else if (o_tok_valid && i_tok_ready) begin
                o_tok_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_token_parser.sv
// Self-checking bench for uart_token_parser: directed scenarios plus random
// byte streams scored against a string-level reference model.
module tb_uart_token_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_clear;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [31:0] o_tok_value;
    logic        o_tok_last;
    logic        o_tok_valid;
    logic        i_tok_ready;
    logic        o_err;
    logic [2:0]  o_err_code;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_val[$];
    bit          obs_last[$];
    int          obs_err[$];
    logic [31:0] exp_val[$];
    bit          exp_last[$];
    int          exp_err[$];

    int m_digits[$];
    bit m_neg;
    bit m_skip;

    uart_token_parser #(.DATA_W(32), .MAX_DIGITS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (i_clear),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_tok_value (o_tok_value),
        .o_tok_last  (o_tok_last),
        .o_tok_valid (o_tok_valid),
        .i_tok_ready (i_tok_ready),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Record every accepted token and every error strobe the DUT produces.
    always @(negedge clk) begin
        if (!rst && !i_clear) begin
            if (o_tok_valid && i_tok_ready) begin
                obs_val.push_back(o_tok_value);
                obs_last.push_back(o_tok_last);
            end
            if (o_err) obs_err.push_back(int'(o_err_code));
        end
    end

    // Reference model: a token is a pending digit list with an optional sign.
    function automatic void mdl_byte(input logic [7:0] b);
        bit     is_d;
        bit     is_dl;
        longint v;
        is_d  = (b >= 8'h30) && (b <= 8'h39);
        is_dl = (b == 8'h20) || (b == 8'h09) || (b == 8'h0D) || (b == 8'h0A);
        if (m_skip) begin
            if (is_dl) m_skip = 1'b0;
            return;
        end
        if (is_d) begin
            if (m_digits.size() == 5) begin
                exp_err.push_back(2);
                m_skip = 1'b1; m_digits.delete(); m_neg = 1'b0;
            end else begin
                m_digits.push_back(int'(b) - 48);
            end
        end else if (b == 8'h2D && !m_neg && m_digits.size() == 0) begin
            m_neg = 1'b1;
        end else if (is_dl) begin
            if (m_digits.size() > 0) begin
                v = 0;
                foreach (m_digits[k]) v = v * 10 + m_digits[k];
                if (m_neg) v = -v;
                exp_val.push_back(v[31:0]);
                exp_last.push_back((b == 8'h0D) || (b == 8'h0A));
            end else if (m_neg) begin
                exp_err.push_back(3);
            end
            m_digits.delete(); m_neg = 1'b0;
        end else begin
            exp_err.push_back(1);
            m_skip = 1'b1; m_digits.delete(); m_neg = 1'b0;
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
        step(gap);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    endtask

    task automatic clear_obs();
        obs_val.delete();
        obs_last.delete();
        obs_err.delete();
    endtask

    task automatic test_reset();
        checks++;
        if ({o_tok_value, o_tok_last, o_tok_valid, o_err, o_err_code, o_busy} !== 39'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {o_tok_value, o_tok_last, o_tok_valid, o_err, o_err_code, o_busy});
        end
    endtask

    task automatic test_tokens();
        i_tok_ready = 1'b1;
        clear_obs();
        send_str("2 3 ", 1);
        step(2);
        checks++;
        if (obs_val.size() != 2 || obs_err.size() != 0) begin
            errors++;
            $display("[TB] FAIL two_tokens_count: got %0d tokens %0d errs, expected 2 tokens 0 errs",
                     obs_val.size(), obs_err.size());
        end else begin
            checks++;
            if (obs_val[0] !== 32'd2 || obs_val[1] !== 32'd3 || obs_last[0] || obs_last[1]) begin
                errors++;
                $display("[TB] FAIL two_tokens_value: got %0d/%0d last %0d/%0d, expected 2/3 last 0/0",
                         obs_val[0], obs_val[1], obs_last[0], obs_last[1]);
            end
        end
        clear_obs();
        send_str("-17", 1);
        checks++;
        if (o_tok_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL neg_pre_lf_valid: got %0d, expected 0", o_tok_valid);
        end
        send_byte(8'h0A, 0);
        checks++;
        if (o_tok_valid !== 1'b1 || o_tok_value !== 32'hFFFF_FFEF || o_tok_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL neg_token: got valid %0d value %h last %0d, expected 1 ffffffef 1",
                     o_tok_valid, o_tok_value, o_tok_last);
        end
        step(1);
        checks++;
        if (o_tok_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL neg_token_drop: got valid %0d, expected 0", o_tok_valid);
        end
    endtask

    task automatic test_digit_limit();
        clear_obs();
        send_str("12345", 1);
        send_byte("6", 0);
        checks++;
        if (o_err !== 1'b1 || o_err_code !== 3'd2) begin
            errors++;
            $display("[TB] FAIL too_many_digits: got err %0d code %0d, expected 1 2", o_err, o_err_code);
        end
        step(1);
        send_str(" 9 ", 1);
        step(2);
        checks++;
        if (obs_val.size() != 1 || obs_err.size() != 1) begin
            errors++;
            $display("[TB] FAIL limit_count: got %0d tokens %0d errs, expected 1 1",
                     obs_val.size(), obs_err.size());
        end else begin
            checks++;
            if (obs_val[0] !== 32'd9) begin
                errors++;
                $display("[TB] FAIL limit_token: got %0d, expected 9", obs_val[0]);
            end
        end
    endtask

    task automatic test_errors();
        clear_obs();
        send_byte("1", 1);
        send_byte("a", 0);
        checks++;
        if (o_err !== 1'b1 || o_err_code !== 3'd1) begin
            errors++;
            $display("[TB] FAIL illegal_char: got err %0d code %0d, expected 1 1", o_err, o_err_code);
        end
        step(1);
        checks++;
        if (o_err !== 1'b0 || o_err_code !== 3'd1) begin
            errors++;
            $display("[TB] FAIL err_one_cycle: got err %0d code %0d, expected 0 1", o_err, o_err_code);
        end
        send_str(" 4 - 5", 1);
        send_byte(8'h0D, 1);
        step(2);
        checks++;
        if (obs_val.size() != 2 || obs_err.size() != 2) begin
            errors++;
            $display("[TB] FAIL errors_count: got %0d tokens %0d errs, expected 2 2",
                     obs_val.size(), obs_err.size());
        end else begin
            checks++;
            if (obs_val[0] !== 32'd4 || obs_val[1] !== 32'd5 || obs_last[0] || !obs_last[1]
                || obs_err[0] != 1 || obs_err[1] != 3) begin
                errors++;
                $display("[TB] FAIL errors_seq: got %0d/%0d last %0d/%0d errs %0d/%0d, expected 4/5 0/1 1/3",
                         obs_val[0], obs_val[1], obs_last[0], obs_last[1], obs_err[0], obs_err[1]);
            end
        end
    endtask

    task automatic test_overrun();
        clear_obs();
        i_tok_ready = 1'b0;
        send_str("7 ", 1);
        send_str("8", 1);
        send_byte(" ", 0);
        checks++;
        if (o_err !== 1'b1 || o_err_code !== 3'd4 || o_tok_valid !== 1'b1 || o_tok_value !== 32'd7) begin
            errors++;
            $display("[TB] FAIL overrun: got err %0d code %0d valid %0d value %0d, expected 1 4 1 7",
                     o_err, o_err_code, o_tok_valid, o_tok_value);
        end
        step(3);
        i_tok_ready = 1'b1;
        step(2);
        checks++;
        if (o_tok_valid !== 1'b0 || obs_val.size() != 1) begin
            errors++;
            $display("[TB] FAIL overrun_drain: got valid %0d tokens %0d, expected 0 1",
                     o_tok_valid, obs_val.size());
        end else begin
            checks++;
            if (obs_val[0] !== 32'd7) begin
                errors++;
                $display("[TB] FAIL overrun_kept: got %0d, expected 7", obs_val[0]);
            end
        end
        clear_obs();
        i_tok_ready = 1'b0;
        send_str("7 8", 1);
        i_rx_data   = " ";
        i_rx_valid  = 1'b1;
        i_tok_ready = 1'b1;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
        checks++;
        if (o_tok_valid !== 1'b1 || o_tok_value !== 32'd8 || o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL same_cycle_accept: got valid %0d value %0d err %0d, expected 1 8 0",
                     o_tok_valid, o_tok_value, o_err);
        end
        step(2);
        checks++;
        if (obs_val.size() != 2 || obs_err.size() != 0) begin
            errors++;
            $display("[TB] FAIL same_cycle_count: got %0d tokens %0d errs, expected 2 0",
                     obs_val.size(), obs_err.size());
        end else begin
            checks++;
            if (obs_val[0] !== 32'd7 || obs_val[1] !== 32'd8) begin
                errors++;
                $display("[TB] FAIL same_cycle_order: got %0d/%0d, expected 7/8", obs_val[0], obs_val[1]);
            end
        end
    endtask

    task automatic test_clear();
        clear_obs();
        i_tok_ready = 1'b1;
        send_str("45", 1);
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({o_tok_value, o_tok_last, o_tok_valid, o_err, o_err_code, o_busy} !== 39'd0) begin
            errors++;
            $display("[TB] FAIL clear_outputs: got %h, expected 0",
                     {o_tok_value, o_tok_last, o_tok_valid, o_err, o_err_code, o_busy});
        end
        i_rx_data  = "9";
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_clear    = 1'b0;
        i_rx_valid = 1'b0;
        send_str("6 ", 1);
        step(2);
        checks++;
        if (obs_val.size() != 1 || obs_val[0] !== 32'd6) begin
            errors++;
            $display("[TB] FAIL clear_token: got %0d tokens first %0d, expected 1 token 6",
                     obs_val.size(), (obs_val.size() > 0) ? obs_val[0] : 32'd0);
        end
        i_tok_ready = 1'b0;
        send_str("x 3 45", 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({o_tok_value, o_tok_last, o_tok_valid, o_err, o_err_code, o_busy} !== 39'd0) begin
            errors++;
            $display("[TB] FAIL rst_outputs: got %h, expected 0",
                     {o_tok_value, o_tok_last, o_tok_valid, o_err, o_err_code, o_busy});
        end
        clear_obs();
        i_tok_ready = 1'b1;
        send_str("6 ", 1);
        step(2);
        checks++;
        if (obs_val.size() != 1 || obs_val[0] !== 32'd6 || obs_err.size() != 0) begin
            errors++;
            $display("[TB] FAIL rst_token: got %0d tokens %0d errs, expected 1 token 6 0 errs",
                     obs_val.size(), obs_err.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         r;
        i_tok_ready = 1'b1;
        m_digits.delete();
        m_neg  = 1'b0;
        m_skip = 1'b0;
        for (int it = 0; it < 8; it++) begin
            clear_obs();
            exp_val.delete();
            exp_last.delete();
            exp_err.delete();
            for (int n = 0; n < 24; n++) begin
                r = $urandom_range(0, 15);
                if (n == 23)     b = 8'h20;
                else if (r <= 8) b = 8'(8'h30 + $urandom_range(0, 9));
                else if (r == 9) b = 8'h20;
                else if (r == 10) b = 8'h2D;
                else if (r == 11) b = 8'h0D;
                else if (r == 12) b = 8'h0A;
                else if (r == 13) b = 8'h09;
                else if (r == 14) b = 8'(8'h41 + $urandom_range(0, 25));
                else             b = 8'(8'h30 + $urandom_range(0, 9));
                mdl_byte(b);
                send_byte(b, $urandom_range(0, 2));
            end
            step(3);
            checks++;
            if (obs_val.size() != exp_val.size() || obs_err.size() != exp_err.size()) begin
                errors++;
                $display("[TB] FAIL random_count it%0d: got %0d tokens %0d errs, expected %0d tokens %0d errs",
                         it, obs_val.size(), obs_err.size(), exp_val.size(), exp_err.size());
            end else begin
                foreach (exp_val[k]) begin
                    checks++;
                    if (obs_val[k] !== exp_val[k] || obs_last[k] != exp_last[k]) begin
                        errors++;
                        $display("[TB] FAIL random_token it%0d #%0d: got %0d last %0d, expected %0d last %0d",
                                 it, k, $signed(obs_val[k]), obs_last[k], $signed(exp_val[k]), exp_last[k]);
                    end
                end
                foreach (exp_err[k]) begin
                    checks++;
                    if (obs_err[k] != exp_err[k]) begin
                        errors++;
                        $display("[TB] FAIL random_err it%0d #%0d: got %0d, expected %0d",
                                 it, k, obs_err[k], exp_err[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_clear     = 1'b0;
        i_rx_data   = 8'h00;
        i_rx_valid  = 1'b0;
        i_tok_ready = 1'b0;
        step(2);
        test_reset();
        rst = 1'b0;
        step(1);
        $display("[TB] starting directed scenarios");
        test_tokens();
        test_digit_limit();
        test_errors();
        test_overrun();
        test_clear();
        $display("[TB] starting random streams");
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_token_parser.md
Name: uart_token_parser

Overview:
Converts the raw UART byte stream into signed decimal integer tokens for the matrix input path. Sits between the UART byte receiver and Input_Subsystem. Consumes one byte per rx_valid pulse and emits one token per completed number. Tokens carry a flag marking end of line, and each illegal input reports an error code.

Parameters:
DATA_W, 32, width of emitted token value (two's complement)
MAX_DIGITS, 5, maximum decimal digits per token; must satisfy 10^MAX_DIGITS-1 < 2^(DATA_W-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_clear  in  1  synchronous flush from FSM (leave input mode / abort)
i_rx_data  in  8  received byte
i_rx_valid  in  1  single-cycle strobe, i_rx_data valid
o_tok_value  out  DATA_W  signed token value
o_tok_last  out  1  token was terminated by CR or LF
o_tok_valid  out  1  token held, valid until accepted
i_tok_ready  in  1  consumer accepts token when o_tok_valid & i_tok_ready
o_err  out  1  single-cycle error strobe
o_err_code  out  3  1=illegal char, 2=too many digits, 3=lone '-', 4=token overrun; held until next error
o_busy  out  1  high in SIGN or DIGITS states

Behaviour:
- Reset and i_clear: all outputs 0; state IDLE; accumulator, digit count and sign cleared; held token dropped. Priority: rst > i_clear > i_rx_valid. A byte arriving in the same cycle as i_clear is discarded.
- Byte classes: digit 0x30-0x39; delimiter = 0x20, 0x09, 0x0D, 0x0A; minus 0x2D; every other byte is illegal.
- States: IDLE, SIGN, DIGITS, SKIP. Transitions occur only on cycles where i_rx_valid is high.
- IDLE:
  - digit -> DIGITS, acc=digit, cnt=1.
  - minus -> SIGN, neg=1.
  - delimiter -> stay, no token (consecutive delimiters are harmless).
  - illegal -> err 1, go to SKIP.
- SIGN:
  - digit -> DIGITS.
  - delimiter -> err 3, go to IDLE.
  - minus or illegal -> err 1, go to SKIP.
- DIGITS:
  - digit with cnt<MAX_DIGITS -> acc=acc*10+digit (computed as acc<<3 + acc<<1), cnt+1.
  - digit with cnt==MAX_DIGITS -> err 2, go to SKIP.
  - delimiter -> emit token, go to IDLE.
  - minus or illegal -> err 1, go to SKIP.
- SKIP: discards all bytes until a delimiter, then goes to IDLE. Emits no token and no further errors.
- Emit:
  - Value = neg ? -acc : acc. o_tok_last=1 if the delimiter was CR or LF.
  - Latency: delimiter strobe in cycle N -> o_tok_valid high in cycle N+1.
  - acc, cnt and neg are cleared on emit.
- Output handshake: o_tok_value and o_tok_last stay stable while o_tok_valid is high and not accepted. o_tok_valid falls the cycle after acceptance.
- Overrun: if a token completes while o_tok_valid & ~i_tok_ready, raise err 4, drop the new token and keep the held one. If the held token is accepted in the same cycle the new token completes, load the new token (o_tok_valid stays high).
- o_err pulses exactly one cycle, in cycle N+1 after the offending byte.
- "-0" emits 0. Leading zeros count toward MAX_DIGITS.

Decomposition:
- Shared package: ASCII constants (SPACE, TAB, CR, LF, MINUS, ZERO, NINE), error code constants, and the state encoding.
- Sub-module ascii_classifier: combinational byte -> {is_digit, is_delim, is_eol, is_minus, digit_val[3:0]}. It is reusable by the command parser.
- The parser FSM, accumulator and output register stay in uart_token_parser.

Test Plan:
1. Bytes "2 3 " with i_tok_ready=1 -> tokens 2 then 3, o_tok_last=0, no o_err.
2. Bytes "-17\n" -> one token, value 0xFFFFFFEF, o_tok_last=1, valid exactly 1 cycle after the LF strobe.
3. Bytes "123456 9 " with MAX_DIGITS=5 -> err code 2 on the '6' byte, then a single token 9; the digits 1-5 are not emitted.
4. Bytes "1a 4 - 5\r" -> err 1 on 'a', token 4, err 3 on the lone '-', then token 5 with last=1.
5. i_tok_ready=0, bytes "7 8 " -> token 7 held stable, err 4 on 8's delimiter; then ready=1 -> 7 accepted and no 8 appears. Repeat with ready asserted in the completion cycle -> 8 is loaded.
6. Bytes "45" then i_clear pulse, then "6 " -> only token 6. A rst pulse mid-token gives the same result, and all outputs read 0 in the cycle after rst.
